pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V fetch stage; successor to the plain PC register.
- Holds the architectural fetch PC and selects each cycle between sequential increment, branch/jump redirect, trap vector and hold (stall/halt).
- Adds a boot/run/halt FSM, redirect-target alignment checking, and a fetch-valid qualifier for the instruction memory interface.

Parameters:
- XLEN, 64, width of PC and all address ports.
- RESET_VEC, 64'h0, PC value loaded by reset.
- INSN_BYTES, 4, sequential increment. Legal values: 2 or 4. Alignment is checked against log2(INSN_BYTES).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; pipeline back-pressure.
- redirect  input  1  branch/jump taken this cycle.
- redirect_target  input  XLEN  target for redirect.
- trap  input  1  exception/interrupt taken.
- trap_vec  input  XLEN  trap handler address (mtvec); bits [1:0] are ignored (forced 0).
- halt_req  input  1  debug halt request (level).
- resume  input  1  debug resume pulse.
- pc_out  output  XLEN  current fetch PC (registered).
- pc_plus  output  XLEN  pc_out + INSN_BYTES (combinational, mod 2^XLEN).
- pc_valid  output  1  pc_out is a fetch request (registered).
- halted  output  1  FSM in HALTED (registered).
- misalign_err  output  1  one-cycle pulse: rejected misaligned redirect (registered).
- bad_addr  output  XLEN  last rejected redirect target (registered, held).

Behaviour:
- All state updates on posedge clk. No asynchronous paths. pc_plus is the only combinational output.
- Reset (rst=1 at an edge, any state, overrides all other inputs):
  - pc_out=RESET_VEC, state=BOOT, pc_valid=0, halted=0, misalign_err=0, bad_addr=0.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: lasts exactly one cycle after reset deassertion. Next state is RUN. pc_out stays RESET_VEC, pc_valid becomes 1. Other inputs are ignored in BOOT except rst.
  - RUN -> HALTED: on halt_req=1 when trap=0.
  - HALTED -> RUN: on resume=1 or trap=1.
  - If resume and halt_req are both 1, resume wins for that cycle. The FSM re-enters HALTED on the next cycle if halt_req is still 1.
- PC next-value priority in RUN (highest first). Latency is 1 cycle: the new value appears on pc_out after the edge.
  1. trap: pc_out <= {trap_vec[XLEN-1:2],2'b00}. Overrides stall, redirect and halt_req.
  2. redirect with target[log2(INSN_BYTES)-1:0]!=0: rejected. pc_out <= trap_vec (aligned), misalign_err=1 for one cycle, bad_addr <= redirect_target.
  3. redirect, aligned: pc_out <= redirect_target. Overrides stall, because a taken branch flushes.
  4. halt_req: pc_out held, transition to HALTED.
  5. stall: pc_out held, pc_valid stays 1.
  6. otherwise: pc_out <= pc_out + INSN_BYTES. Wraps from 2^XLEN-INSN_BYTES to 0 silently.
- HALTED:
  - pc_valid=0 and halted=1, registered; both take effect the cycle after the FSM enters HALTED.
  - stall is ignored.
  - An aligned redirect updates pc_out and the FSM stays HALTED (debugger writes PC).
  - A misaligned redirect follows rule 2 but the FSM stays HALTED.
  - trap follows rule 1 and the FSM leaves to RUN.
  - On resume, fetch restarts at the held pc_out; no increment on the resume edge.
- misalign_err self-clears the next cycle unless another misaligned redirect occurs.
- bad_addr changes only on a rejected redirect.
- pc_valid=1 in RUN after BOOT; 0 in BOOT and HALTED.

Test Plan:
- Reset then run: rst high 2 cycles, RESET_VEC=0x1000 -> pc_out 0x1000 for the BOOT cycle with pc_valid=0, then 0x1000 (valid), 0x1004, 0x1008.
- Stall vs redirect: at pc_out=0x1008, stall=1 for 3 cycles -> pc_out held at 0x1008. Then stall=1 with redirect=1 to 0x2000 -> pc_out=0x2000 next cycle.
- Trap priority: trap=1, trap_vec=0x8003, redirect=1 to 0x3000, stall=1, all in the same cycle -> pc_out=0x8000, misalign_err=0.
- Misaligned redirect: redirect to 0x2002 with INSN_BYTES=4, trap_vec=0x8000 -> pc_out=0x8000, misalign_err=1 for exactly one cycle, bad_addr=0x2002 held afterwards.
- Halt/resume: halt_req at pc_out=0x1010 -> halted=1, pc_valid=0, PC frozen. Then redirect 0x4000 while halted -> still halted, pc_out=0x4000. Then resume -> pc_out 0x4000 (valid), then 0x4004.
- Wrap and mid-run reset: start at pc_out=0xFFFF_FFFF_FFFF_FFFC, free-run -> next value 0x0. Then assert rst during a stall -> pc_out=RESET_VEC and a BOOT cycle follows.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-side bundle for the program-counter unit: control inputs from the
// pipeline/debug logic and the registered fetch PC toward instruction memory.
interface pc_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;
  logic            halted;
  logic            misalign_err;
  logic [XLEN-1:0] bad_addr;

  // Pipeline/debug side: drives control, observes the fetch PC.
  modport master (
    output stall, redirect, redirect_target, trap, trap_vec, halt_req, resume,
    input  pc_out, pc_plus, pc_valid, halted, misalign_err, bad_addr
  );

  // PC unit side.
  modport slave (
    input  stall, redirect, redirect_target, trap, trap_vec, halt_req, resume,
    output pc_out, pc_plus, pc_valid, halted, misalign_err, bad_addr
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: boot/run/halt FSM, next-PC
// selection (trap > misaligned redirect > redirect > halt > stall > increment),
// redirect alignment checking and a fetch-valid qualifier.
module pc_unit #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int unsigned     INSN_BYTES = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave pc_if
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Low bits that must be zero in a redirect target (INSN_BYTES is 2 or 4).
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);
  // Trap vectors are always word aligned; the two low bits are dropped.
  localparam logic [XLEN-1:0] TVEC_MASK  = ~XLEN'(3);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            halted_q;
  logic            misalign_err_q;
  logic [XLEN-1:0] bad_addr_q;

  logic [XLEN-1:0] trap_target;
  logic            bad_redirect;
  logic            take_jump;
  logic [XLEN-1:0] jump_pc_d;

  // Decode the redirect/trap request into "jump somewhere" plus its target.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    jump_pc_d    = pc_q;
    take_jump    = 1'b0;
    trap_target  = pc_if.trap_vec & TVEC_MASK;
    bad_redirect = pc_if.redirect && ((pc_if.redirect_target & ALIGN_MASK) != '0);
    if (pc_if.trap) begin
      take_jump = 1'b1;
      jump_pc_d = trap_target;
    end else if (bad_redirect) begin
      take_jump = 1'b1;
      jump_pc_d = trap_target;
    end else if (pc_if.redirect) begin
      take_jump = 1'b1;
      jump_pc_d = pc_if.redirect_target;
    end
  end

  // FSM, PC register and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VEC;
      pc_valid_q     <= 1'b0;
      halted_q       <= 1'b0;
      misalign_err_q <= 1'b0;
      bad_addr_q     <= '0;
    end else begin
      misalign_err_q <= 1'b0;
      unique case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
          halted_q   <= 1'b0;
        end
        ST_RUN: begin
          if (take_jump) begin
            pc_q <= jump_pc_d;
          end else if (!pc_if.halt_req && !pc_if.stall) begin
            pc_q <= pc_q + STEP;
          end
          if (!pc_if.trap && bad_redirect) begin
            misalign_err_q <= 1'b1;
            bad_addr_q     <= pc_if.redirect_target;
          end
          if (pc_if.halt_req && !pc_if.trap) begin
            state_q    <= ST_HALTED;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (take_jump) begin
            pc_q <= jump_pc_d;
          end
          if (!pc_if.trap && bad_redirect) begin
            misalign_err_q <= 1'b1;
            bad_addr_q     <= pc_if.redirect_target;
          end
          // Resume restarts fetch at the held PC; no increment on this edge.
          if (pc_if.trap || pc_if.resume) begin
            state_q    <= ST_RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_if.pc_out       = pc_q;
  assign pc_if.pc_plus      = pc_q + STEP;
  assign pc_if.pc_valid     = pc_valid_q;
  assign pc_if.halted       = halted_q;
  assign pc_if.misalign_err = misalign_err_q;
  assign pc_if.bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (XLEN=64, RESET_VEC=0x1000,
// INSN_BYTES=4). Each vector drives inputs for one edge and checks outputs.
module tb_pc_unit;

  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN)) bus ();

  pc_unit #(
    .XLEN      (XLEN),
    .RESET_VEC (64'h1000),
    .INSN_BYTES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pc_if(bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] target;
    logic        trap;
    logic [63:0] tvec;
    logic        halt_req;
    logic        resume;
    logic [63:0] exp_pc;
    logic        exp_valid;
    logic        exp_halted;
    logic        exp_err;
    logic [63:0] exp_bad;
  } vec_t;

  vec_t vecs[$];
  int   n_vectors    = 0;
  int   n_miscompare = 0;

  function automatic vec_t mk(string name, logic r, logic st, logic rd, logic [63:0] tg,
                              logic tp, logic [63:0] tv, logic hr, logic rs,
                              logic [63:0] epc, logic ev, logic eh, logic ee, logic [63:0] eb);
    vec_t v;
    v.name = name; v.rst = r; v.stall = st; v.redirect = rd; v.target = tg;
    v.trap = tp; v.tvec = tv; v.halt_req = hr; v.resume = rs;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_halted = eh; v.exp_err = ee; v.exp_bad = eb;
    return v;
  endfunction

  task automatic check(string name, string field, logic [63:0] act, logic [63:0] exp);
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  // Drive one vector, let one rising edge pass, then sample 1 time unit later.
  task automatic apply(vec_t v);
    rst                 = v.rst;
    bus.stall           = v.stall;
    bus.redirect        = v.redirect;
    bus.redirect_target = v.target;
    bus.trap            = v.trap;
    bus.trap_vec        = v.tvec;
    bus.halt_req        = v.halt_req;
    bus.resume          = v.resume;
    @(posedge clk);
    #1;
    n_vectors++;
    check(v.name, "pc_out",       bus.pc_out,       v.exp_pc);
    check(v.name, "pc_plus",      bus.pc_plus,      v.exp_pc + 64'd4);
    check(v.name, "pc_valid",     64'(bus.pc_valid),     64'(v.exp_valid));
    check(v.name, "halted",       64'(bus.halted),       64'(v.exp_halted));
    check(v.name, "misalign_err", 64'(bus.misalign_err), 64'(v.exp_err));
    check(v.name, "bad_addr",     bus.bad_addr,     v.exp_bad);
    @(negedge clk);
  endtask

  localparam logic [63:0] TV = 64'h8000;

  initial begin
    //                 name           rst st rd target                 tp tvec       hr rs  exp_pc                 v  h  e  bad
    vecs.push_back(mk("reset0",        1, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h1000,              0, 0, 0, 64'h0));
    vecs.push_back(mk("reset1_boot",   1, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h1000,              0, 0, 0, 64'h0));
    vecs.push_back(mk("boot_to_run",   0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h1000,              1, 0, 0, 64'h0));
    vecs.push_back(mk("inc1",          0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h1004,              1, 0, 0, 64'h0));
    vecs.push_back(mk("inc2",          0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h1008,              1, 0, 0, 64'h0));
    vecs.push_back(mk("stall1",        0, 1, 0, 64'h0,                  0, TV,        0, 0, 64'h1008,              1, 0, 0, 64'h0));
    vecs.push_back(mk("stall2",        0, 1, 0, 64'h0,                  0, TV,        0, 0, 64'h1008,              1, 0, 0, 64'h0));
    vecs.push_back(mk("stall3",        0, 1, 0, 64'h0,                  0, TV,        0, 0, 64'h1008,              1, 0, 0, 64'h0));
    vecs.push_back(mk("stall_redir",   0, 1, 1, 64'h2000,               0, TV,        0, 0, 64'h2000,              1, 0, 0, 64'h0));
    vecs.push_back(mk("trap_prio",     0, 1, 1, 64'h3000,               1, 64'h8003,  0, 0, 64'h8000,              1, 0, 0, 64'h0));
    vecs.push_back(mk("after_trap",    0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h8004,              1, 0, 0, 64'h0));
    vecs.push_back(mk("misalign",      0, 0, 1, 64'h2002,               0, TV,        0, 0, 64'h8000,              1, 0, 1, 64'h2002));
    vecs.push_back(mk("err_clears",    0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h8004,              1, 0, 0, 64'h2002));
    vecs.push_back(mk("redir_1010",    0, 0, 1, 64'h1010,               0, TV,        0, 0, 64'h1010,              1, 0, 0, 64'h2002));
    vecs.push_back(mk("halt",          0, 0, 0, 64'h0,                  0, TV,        1, 0, 64'h1010,              0, 1, 0, 64'h2002));
    vecs.push_back(mk("halt_stall",    0, 1, 0, 64'h0,                  0, TV,        1, 0, 64'h1010,              0, 1, 0, 64'h2002));
    vecs.push_back(mk("halt_redir",    0, 0, 1, 64'h4000,               0, TV,        0, 0, 64'h4000,              0, 1, 0, 64'h2002));
    vecs.push_back(mk("resume",        0, 0, 0, 64'h0,                  0, TV,        0, 1, 64'h4000,              1, 0, 0, 64'h2002));
    vecs.push_back(mk("post_resume",   0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h4004,              1, 0, 0, 64'h2002));
    vecs.push_back(mk("to_top",        0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, TV,       0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 64'h2002));
    vecs.push_back(mk("wrap",          0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h0,                 1, 0, 0, 64'h2002));
    vecs.push_back(mk("after_wrap",    0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h4,                 1, 0, 0, 64'h2002));
    vecs.push_back(mk("stall_pre_rst", 0, 1, 0, 64'h0,                  0, TV,        0, 0, 64'h4,                 1, 0, 0, 64'h2002));
    vecs.push_back(mk("rst_in_stall",  1, 1, 0, 64'h0,                  0, TV,        0, 0, 64'h1000,              0, 0, 0, 64'h0));
    vecs.push_back(mk("boot_again",    0, 1, 0, 64'h0,                  0, TV,        0, 0, 64'h1000,              1, 0, 0, 64'h0));
    vecs.push_back(mk("run_again",     0, 0, 0, 64'h0,                  0, TV,        0, 0, 64'h1004,              1, 0, 0, 64'h0));

    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Halted corner cases: misaligned redirect stays halted, resume beats
    // halt_req for one cycle, trap leaves HALTED.
    apply(mk("h_halt",         0, 0, 0, 64'h0,    0, TV,       1, 0, 64'h1004, 0, 1, 0, 64'h0));
    apply(mk("h_misalign",     0, 0, 1, 64'h4002, 0, TV,       0, 0, 64'h8000, 0, 1, 1, 64'h4002));
    apply(mk("h_err_clears",   0, 0, 0, 64'h0,    0, TV,       0, 0, 64'h8000, 0, 1, 0, 64'h4002));
    apply(mk("h_resume_wins",  0, 0, 0, 64'h0,    0, TV,       1, 1, 64'h8000, 1, 0, 0, 64'h4002));
    apply(mk("h_rehalt",       0, 0, 0, 64'h0,    0, TV,       1, 0, 64'h8000, 0, 1, 0, 64'h4002));
    apply(mk("h_trap_leaves",  0, 0, 0, 64'h0,    1, 64'h9007, 0, 0, 64'h9004, 1, 0, 0, 64'h4002));
    apply(mk("h_run_on",       0, 0, 0, 64'h0,    0, 64'h9004, 0, 0, 64'h9008, 1, 0, 0, 64'h4002));

    // Back-to-back misaligned redirects keep the error pulse high.
    apply(mk("mis_a",          0, 0, 1, 64'h5001, 0, 64'h9004, 0, 0, 64'h9004, 1, 0, 1, 64'h5001));
    apply(mk("mis_b",          0, 0, 1, 64'h5003, 0, 64'h9004, 0, 0, 64'h9004, 1, 0, 1, 64'h5003));
    apply(mk("mis_clear",      0, 0, 0, 64'h0,    0, 64'h9004, 0, 0, 64'h9008, 1, 0, 0, 64'h5003));

    // Trap blocks a simultaneous halt request.
    apply(mk("trap_vs_halt",   0, 0, 0, 64'h0,    1, 64'hA000, 1, 0, 64'hA000, 1, 0, 0, 64'h5003));
    apply(mk("after_tvh",      0, 0, 0, 64'h0,    0, 64'hA000, 0, 0, 64'hA004, 1, 0, 0, 64'h5003));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
    $finish;
  end

endmodule
